// File: rtl/pwm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_controller
//  Purpose  : Drives 16 output pins with constant or PWM levels from the
//             SPI-written enable and duty registers. A shared timebase
//             (prescaler + 8-bit period counter) runs only while at least
//             one pin is in PWM mode. The duty value is shadowed and only
//             reloaded at period boundaries, so duty changes never glitch
//             the waveform mid-period.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_controller #(
  parameter int PRESCALE = 3000,  // clk cycles per PWM tick (>=1)
  parameter int PRE_W    = 12     // prescaler width, 2**PRE_W >= PRESCALE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] en_out,
  input  logic [15:0] en_pwm,
  input  logic [7:0]  duty,
  output logic [15:0] out,
  output logic [7:0]  duty_active,
  output logic        period_start
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [7:0]       C_CNT_LAST = 8'd254;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_active_q, duty_active_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q, period_start_d;

  logic             w_run_req;
  logic             w_tick;
  logic             w_wrap;
  logic             w_pwm_lvl;

  assign w_run_req = |(en_out & en_pwm);
  assign w_tick    = (state_q == ST_RUN) && (pre_q == C_PRE_LAST);
  assign w_wrap    = w_tick && (cnt_q == C_CNT_LAST);

  // PWM comparator: full-scale duty is forced high so 0xFF means a solid 1
  // even though the counter never reaches 255.
  assign w_pwm_lvl = (duty_active_q == 8'hFF) ? 1'b1 : (cnt_q < duty_active_q);

  // Next-state logic for the FSM, timebase, shadow duty and pin drive.
  always_comb begin
    state_d        = state_q;
    pre_d          = pre_q;
    cnt_d          = cnt_q;
    duty_active_d  = duty_active_q;
    period_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Timebase parked at zero; shadow duty follows the register freely.
        pre_d         = '0;
        cnt_d         = 8'd0;
        duty_active_d = duty;
        if (w_run_req) begin
          state_d        = ST_RUN;
          period_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_run_req) begin
          // Stop immediately rather than finishing the period.
          state_d = ST_IDLE;
          pre_d   = '0;
          cnt_d   = 8'd0;
        end else if (w_tick) begin
          pre_d = '0;
          if (w_wrap) begin
            cnt_d          = 8'd0;
            duty_active_d  = duty;
            period_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pre_d   = '0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Per-pin output select: disabled pins low, constant pins high, PWM pins
  // follow the shared comparator.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < 16; i++) begin
      out_d[i] = en_out[i] ? (en_pwm[i] ? w_pwm_lvl : 1'b1) : 1'b0;
    end
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pre_q          <= '0;
      cnt_q          <= 8'd0;
      duty_active_q  <= 8'd0;
      out_q          <= 16'd0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      duty_active_q  <= duty_active_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign duty_active  = duty_active_q;
  assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_controller
//  Purpose  : Directed self-checking bench for pwm_controller with
//             PRESCALE=4 (one PWM period = 1020 clk cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_controller;

  logic        clk;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic [7:0]  duty_active;
  logic        period_start;

  int n_vec;
  int n_err;

  pwm_controller #(
    .PRESCALE(4),
    .PRE_W   (3)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en_out      (en_out),
    .en_pwm      (en_pwm),
    .duty        (duty),
    .out         (out),
    .duty_active (duty_active),
    .period_start(period_start)
  );

  // 10 ns clock; inputs driven and outputs sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs n cycles, counting out[0] high samples and period_start pulses;
  // last_at is the 1-based index of the last pulse within the window.
  task automatic window(input int n, output int highs, output int pulses, output int last_at);
    highs   = 0;
    pulses  = 0;
    last_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (out[0]) highs++;
      if (period_start) begin
        pulses++;
        last_at = i;
      end
    end
  endtask

  int h, p, l;

  initial begin
    n_vec  = 0;
    n_err  = 0;

    // 1. reset with every input nonzero
    rst    = 1'b1;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'hAA;
    @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_duty", 32'(duty_active), 32'h0);
    chk("rst_ps", 32'(period_start), 32'h0);
    @(negedge clk);

    // 2. constant outputs only, timebase idle
    rst    = 1'b0;
    en_out = 16'h00FF;
    en_pwm = 16'h0000;
    duty   = 8'h33;
    @(negedge clk);
    chk("const_out", 32'(out), 32'h00FF);
    chk("idle_duty_track", 32'(duty_active), 32'h33);
    window(20, h, p, l);
    chk("idle_no_ps", 32'(p), 32'd0);
    chk("const_high", 32'(h), 32'd20);

    // 3. PWM on pin 0 at duty 0x80: 512 high, 508 low, period 1020
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    @(negedge clk);
    chk("start_ps", 32'(period_start), 32'h1);
    chk("start_duty", 32'(duty_active), 32'h80);
    chk("start_out", 32'(out), 32'h0001);
    window(512, h, p, l);
    chk("p1_high_time", 32'(h), 32'd512);
    chk("p1_no_ps", 32'(p), 32'd0);
    window(508, h, p, l);
    chk("p1_low_time", 32'(h), 32'd0);
    chk("p1_wrap_ps", 32'(p), 32'd1);
    chk("p1_wrap_at", 32'(l), 32'd508);

    // 5. mid-period duty write is deferred to the next period start
    window(100, h, p, l);
    duty = 8'h40;
    chk("mid_write_hold", 32'(duty_active), 32'h80);
    window(920, h, p, l);
    chk("p2_high_rest", 32'(h), 32'd412);
    chk("p2_wrap_at", 32'(l), 32'd920);
    chk("p2_new_duty", 32'(duty_active), 32'h40);
    window(1019, h, p, l);
    chk("p3_high_time", 32'(h), 32'd256);
    chk("p3_no_ps", 32'(p), 32'd0);
    // duty written in the cycle of the wrap tick is captured
    duty = 8'hFF;
    window(1, h, p, l);
    chk("wrap_cycle_ps", 32'(p), 32'd1);
    chk("wrap_cycle_capture", 32'(duty_active), 32'hFF);

    // 4. 0xFF stays high across wraps; 0x00 stays low
    window(1100, h, p, l);
    chk("ff_high", 32'(h), 32'd1100);
    chk("ff_wrap_at", 32'(l), 32'd1020);
    duty = 8'h00;
    window(940, h, p, l);
    chk("to_zero_wrap_at", 32'(l), 32'd940);
    chk("to_zero_duty", 32'(duty_active), 32'h00);
    window(1020, h, p, l);
    chk("zero_low", 32'(h), 32'd0);
    chk("zero_wrap_at", 32'(l), 32'd1020);

    // 6. reset mid-period, then restart from cnt=0
    duty = 8'h80;
    window(300, h, p, l);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", 32'(out), 32'h0);
    chk("midrst_duty", 32'(duty_active), 32'h0);
    chk("midrst_ps", 32'(period_start), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_ps", 32'(period_start), 32'h1);
    chk("restart_duty", 32'(duty_active), 32'h80);
    chk("restart_out", 32'(out), 32'h0);
    window(512, h, p, l);
    chk("restart_high", 32'(h), 32'd512);
    window(508, h, p, l);
    chk("restart_low", 32'(h), 32'd0);
    chk("restart_wrap_at", 32'(l), 32'd508);

    // RUN->IDLE immediately when the last PWM pin is released
    en_pwm = 16'h0000;
    @(negedge clk);
    chk("stop_out", 32'(out), 32'h0001);
    chk("stop_ps", 32'(period_start), 32'h0);
    duty = 8'h55;
    @(negedge clk);
    chk("stop_duty_track", 32'(duty_active), 32'h55);
    window(10, h, p, l);
    chk("stop_no_ps", 32'(p), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
